timer_tima: RTL and testbench
=============================

// Module: timer_tima
// PURPOSE
//  Programmable timer (TIMA FF05 / TMA FF06 / TAC FF07); consumer end of the divider in clocks_reset.
//  Counts falling edges of a TAC-selected divider tap and reloads TIMA from TMA on overflow.
//  Raises a one-cycle timer interrupt request on each reload.
//  Sits on the CPU data bus d; DIV (FF04) stays in the divider.
// PARAMETERS
//  TAC_PAD    5'b11111  value returned in TAC read bits [7:3]
//  TIMA_RST   8'h00     reset value of TIMA and TMA
// PORTS
//  boga1mhz   in     1  M-cycle clock; all state changes on its rising edge
//  reset      in     1  asynchronous, active-high reset
//  d          inout  8  CPU data bus; driven only during reads of FF05-FF07, else 'z
//  cpu_wr     in     1  write strobe; high for exactly one boga1mhz cycle per write
//  cpu_rd     in     1  read strobe (level)
//  ff04_ff07  in     1  address decode: A in FF04..FF07
//  tola_na1   in     1  inverted A1
//  tovy_na0   in     1  inverted A0
//  _4096hz    in     1  divider tap, TAC[1:0]=00
//  _262144hz  in     1  divider tap, TAC[1:0]=01
//  _65536hz   in     1  divider tap, TAC[1:0]=10
//  _16384hz   in     1  divider tap, TAC[1:0]=11
//  int_timer  out    1  timer interrupt request; one-cycle pulse
// BEHAVIOUR
//  Register select, gated by ff04_ff07:
//  - TIMA: !tola_na1 -> no; tola_na1 && !tovy_na0 (A=01)
//  - TMA: !tola_na1 && tovy_na0 (A=10)
//  - TAC: !tola_na1 && !tovy_na0 (A=11)
//  - A=00 (DIV) ignored here.
//  Reset (async): TIMA=TMA=TIMA_RST; TAC=0; tap_q=0; state=RUN; int_timer=0; d='z.
//  Reads: combinational while cpu_rd && select.
//  - TIMA and TMA return the current register value.
//  - TAC returns {TAC_PAD, tac[2:0]}.
//  Writes: take effect at the rising edge with cpu_wr=1. TAC stores d[2:0]; d[7:3] discarded.
//  Tick:
//  - sel = tac[2] & mux(tac[1:0]) taps; tap_q <= sel every edge.
//  - inc = tap_q & !sel.
//  - Clearing tac[2] or switching the mux while the tap is high therefore produces one inc (DMG glitch, required).
//  State machine {RUN, OVF, RELOAD}, every edge E:
//  - RUN:
//    - TIMA write -> TIMA=d (write beats a same-edge inc).
//    - Else inc && TIMA!=FF -> TIMA+1.
//    - inc && TIMA==FF -> TIMA=00, go OVF.
//  - OVF (TIMA reads 00 for exactly one cycle):
//    - TIMA write at E -> TIMA=d, go RUN, no interrupt (reload cancelled).
//    - Else TIMA=TMA, go RELOAD, int_timer=1.
//    - If TMA is written at the same E, the new d value is loaded into both TIMA and TMA.
//    - inc at E is dropped.
//  - RELOAD (int_timer high this cycle only):
//    - TIMA write at E ignored.
//    - TMA write at E sets TMA=d and TIMA=d.
//    - Else inc applies as in RUN.
//    - Go RUN; int_timer=0.
//  - An inc at the end of RELOAD with TIMA==FF re-enters OVF (back-to-back overflow legal).
//  TAC and TMA writes are accepted in every state.
//  Width: TIMA is 8-bit, wraps FF->00 only through OVF.
//  Reset mid-OVF/RELOAD -> RUN, int_timer drops immediately, no interrupt.
// TESTING
//  1. TAC=05 (262144hz), TIMA=FE, TMA=A0, 2 tap falling edges -> TIMA FF; then 00 for 1 cycle; next cycle A0 with int_timer=1 for 1 cycle.
//  2. Overflow to 00, write TIMA=33 during OVF -> TIMA=33, int_timer never asserts, TMA unchanged.
//  3. In RELOAD, write TIMA=55 -> ignored; write TMA=77 instead -> TIMA=TMA=77.
//  4. TAC=04, hold _4096hz high, write TAC=00 -> exactly one inc (TIMA 10->11); taps toggling afterwards -> no change.
//  5. Reads: TAC=06 -> FE on d; TIMA/TMA read back written values; no select or cpu_rd=0 -> d='z.
//  6. Assert reset during OVF -> TIMA=TMA=00, TAC=0, int_timer=0, no pulse after release.

Source files
------------

// File: rtl/timer_tima.sv
// timer_tima: programmable timer (TIMA FF05 / TMA FF06 / TAC FF07).
// Counts falling edges of a TAC-selected divider tap. On overflow it reloads
// TIMA from TMA after one cycle of TIMA=00 and pulses int_timer for one cycle.
// Its register contents appear on the CPU data bus d only during a selected read.
module timer_tima #(
    parameter logic [4:0] TAC_PAD  = 5'b11111,
    parameter logic [7:0] TIMA_RST = 8'h00
) (
    input  logic       boga1mhz,
    input  logic       reset,
    inout  wire  [7:0] d,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       ff04_ff07,
    input  logic       tola_na1,
    input  logic       tovy_na0,
    input  logic       _4096hz,
    input  logic       _262144hz,
    input  logic       _65536hz,
    input  logic       _16384hz,
    output logic       int_timer
);

    // Overflow sequencing states
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_OVF    = 2'd1;
    localparam logic [1:0] ST_RELOAD = 2'd2;

    logic [7:0] tima;
    logic [7:0] tma;
    logic [2:0] tac;
    logic [1:0] state;
    logic       tap_q;

    logic [7:0] tima_nx;
    logic [1:0] state_nx;
    logic       int_nx;

    logic       tap_mux;
    logic       tap_sel;
    logic       inc;
    logic       sel_tima;
    logic       sel_tma;
    logic       sel_tac;
    logic       tima_wr;
    logic       tma_wr;
    logic       tac_wr;
    logic [7:0] rd_data;

    // The tola/tovy inputs are inverted address bits: A=01 TIMA, 10 TMA, 11 TAC.
    assign sel_tima = ff04_ff07 &  tola_na1 & ~tovy_na0;
    assign sel_tma  = ff04_ff07 & ~tola_na1 &  tovy_na0;
    assign sel_tac  = ff04_ff07 & ~tola_na1 & ~tovy_na0;

    assign tima_wr  = cpu_wr & sel_tima;
    assign tma_wr   = cpu_wr & sel_tma;
    assign tac_wr   = cpu_wr & sel_tac;

    // Divider tap selected by TAC[1:0]
    always_comb begin
        case (tac[1:0])
            2'b00:   tap_mux = _4096hz;
            2'b01:   tap_mux = _262144hz;
            2'b10:   tap_mux = _65536hz;
            default: tap_mux = _16384hz;
        endcase
    end

    // The enable gates the tap before the edge detector, so disabling the timer
    // or retargeting the mux while the tap is high yields one increment, as on DMG.
    assign tap_sel = tac[2] & tap_mux;
    assign inc     = tap_q & ~tap_sel;

    // Next TIMA value, overflow sequencing and interrupt request
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        tima_nx  = tima;
        state_nx = ST_RUN;
        int_nx   = 1'b0;
        case (state)
            ST_RUN: begin
                if (tima_wr) begin
                    tima_nx = d;
                end else if (inc) begin
                    if (tima == 8'hFF) begin
                        tima_nx  = 8'h00;
                        state_nx = ST_OVF;
                    end else begin
                        tima_nx = tima + 8'd1;
                    end
                end
            end
            ST_OVF: begin
                // A TIMA write here cancels the reload; any inc is dropped.
                if (tima_wr) begin
                    tima_nx = d;
                end else begin
                    tima_nx  = tma_wr ? d : tma;
                    state_nx = ST_RELOAD;
                    int_nx   = 1'b1;
                end
            end
            ST_RELOAD: begin
                // TIMA writes lose to the reload; a TMA write passes through to TIMA.
                if (tma_wr) begin
                    tima_nx = d;
                end else if (inc) begin
                    if (tima == 8'hFF) begin
                        tima_nx  = 8'h00;
                        state_nx = ST_OVF;
                    end else begin
                        tima_nx = tima + 8'd1;
                    end
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // Register state update on the M-cycle clock
    always_ff @(posedge boga1mhz or posedge reset) begin
        if (reset) begin
            tima      <= TIMA_RST;
            tma       <= TIMA_RST;
            tac       <= 3'b000;
            tap_q     <= 1'b0;
            state     <= ST_RUN;
            int_timer <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // values from before this edge, independent of statement order.
            tap_q     <= tap_sel;
            tima      <= tima_nx;
            state     <= state_nx;
            int_timer <= int_nx;
            if (tma_wr) begin
                tma <= d;
            end
            if (tac_wr) begin
                tac <= d[2:0];
            end
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_data = 8'h00;
        if (sel_tima) begin
            rd_data = tima;
        end else if (sel_tma) begin
            rd_data = tma;
        end else if (sel_tac) begin
            rd_data = {TAC_PAD, tac};
        end
    end

    assign d = (cpu_rd && (sel_tima || sel_tma || sel_tac)) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_timer_tima.sv
// tb_timer_tima: directed tests for timer_tima with a cycle-level reference model.
// The bench drives d only while writing; d is pulled high, so an undriven bus reads FF.
module tb_timer_tima;

    logic       clk;
    logic       reset;
    logic       cpu_wr;
    logic       cpu_rd;
    logic       ff_sel;
    logic [1:0] addr;
    logic       t4096;
    logic       t262144;
    logic       t65536;
    logic       t16384;
    logic       tb_drv;
    logic [7:0] tb_d;
    logic       int_timer;
    wire  [7:0] d;

    int n_cmp;
    int n_bad;

    assign d = tb_drv ? tb_d : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (d[i]);
    end

    timer_tima dut (
        .boga1mhz  (clk),
        .reset     (reset),
        .d         (d),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .ff04_ff07 (ff_sel),
        .tola_na1  (~addr[1]),
        .tovy_na0  (~addr[0]),
        ._4096hz   (t4096),
        ._262144hz (t262144),
        ._65536hz  (t65536),
        ._16384hz  (t16384),
        .int_timer (int_timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 = counting, 1 = the cycle TIMA shows 00 after overflow,
    //        2 = the cycle right after the reload (interrupt visible).
    logic [7:0] m_tima;
    logic [7:0] m_tma;
    logic [2:0] m_tac;
    logic       m_prev;
    logic [1:0] m_phase;

    // Model update at each clock edge
    always @(posedge clk or posedge reset) begin : model
        logic [3:0] taps;
        logic       sel_now;
        logic       tick;
        logic       w_tima;
        logic       w_tma;
        logic       w_tac;
        if (reset) begin
            m_tima  <= 8'h00;
            m_tma   <= 8'h00;
            m_tac   <= 3'b000;
            m_prev  <= 1'b0;
            m_phase <= 2'd0;
        end else begin
            taps    = {t16384, t65536, t262144, t4096};
            sel_now = m_tac[2] && taps[m_tac[1:0]];
            tick    = m_prev && !sel_now;
            w_tima  = cpu_wr && ff_sel && (addr == 2'd1);
            w_tma   = cpu_wr && ff_sel && (addr == 2'd2);
            w_tac   = cpu_wr && ff_sel && (addr == 2'd3);
            m_prev <= sel_now;
            if (w_tma) m_tma <= tb_d;
            if (w_tac) m_tac <= tb_d[2:0];
            m_phase <= 2'd0;
            if (m_phase == 2'd1) begin
                if (w_tima) begin
                    m_tima <= tb_d;
                end else begin
                    m_tima  <= w_tma ? tb_d : m_tma;
                    m_phase <= 2'd2;
                end
            end else if (m_phase == 2'd0 && w_tima) begin
                m_tima <= tb_d;
            end else if (m_phase == 2'd2 && w_tma) begin
                m_tima <= tb_d;
            end else if (tick) begin
                if (m_tima == 8'hFF) begin
                    m_tima  <= 8'h00;
                    m_phase <= 2'd1;
                end else begin
                    m_tima <= m_tima + 8'd1;
                end
            end
        end
    end

    function automatic logic [7:0] model_bus();
        if (cpu_rd && ff_sel) begin
            case (addr)
                2'd1:    return m_tima;
                2'd2:    return m_tma;
                2'd3:    return {5'b11111, m_tac};
                default: return 8'hFF;
            endcase
        end
        return 8'hFF;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!tb_drv) check("cyc_bus", d, model_bus());
        check("cyc_int", {7'b0, int_timer}, {7'b0, (m_phase == 2'd2)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic wr, input logic rd, input logic ff,
                       input logic [1:0] a, input logic [7:0] v);
        cpu_wr = wr; cpu_rd = rd; ff_sel = ff; addr = a; tb_drv = wr; tb_d = v;
        @(posedge clk);
        #1;
        cpu_wr = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        cyc(1'b1, 1'b0, 1'b1, a, v);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, 1'b1, 1'b1, a, 8'h00);
    endtask

    // Read register a for one cycle and compare against hand-computed values
    task automatic peek(input logic [1:0] a, input logic [7:0] exp_d,
                        input logic exp_int, input string name);
        cpu_wr = 1'b0; tb_drv = 1'b0; cpu_rd = 1'b1; ff_sel = 1'b1; addr = a;
        #1;
        check(name, d, exp_d);
        check({name, "_int"}, {7'b0, int_timer}, {7'b0, exp_int});
        @(posedge clk);
        #1;
    endtask

    // One cycle with no selected read: the bus must float (pulled to FF)
    task automatic peek_float(input logic rd_en, input logic ff, input logic [1:0] a,
                              input string name);
        cpu_wr = 1'b0; tb_drv = 1'b0; cpu_rd = rd_en; ff_sel = ff; addr = a;
        #1;
        check(name, d, 8'hFF);
        @(posedge clk);
        #1;
    endtask

    // Produce one falling edge of the 262144 Hz tap (inc lands during the 2nd cycle)
    task automatic fall262();
        t262144 = 1'b1;
        rd(2'd1);
        t262144 = 1'b0;
        rd(2'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        cpu_wr = 1'b0; cpu_rd = 1'b0; ff_sel = 1'b0; addr = 2'd0;
        tb_drv = 1'b0; tb_d = 8'h00;
        t4096 = 1'b0; t262144 = 1'b0; t65536 = 1'b0; t16384 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        peek(2'd1, 8'h00, 1'b0, "rst_tima");
        peek(2'd2, 8'h00, 1'b0, "rst_tma");
        peek(2'd3, 8'hF8, 1'b0, "rst_tac");

        // 1: FE -> FF -> 00 (one cycle) -> A0 with a one-cycle interrupt
        wr(2'd3, 8'h05);
        wr(2'd2, 8'hA0);
        wr(2'd1, 8'hFE);
        fall262();
        t262144 = 1'b1;
        peek(2'd1, 8'hFF, 1'b0, "t1_ff");
        t262144 = 1'b0;
        peek(2'd1, 8'hFF, 1'b0, "t1_ff_hold");
        peek(2'd1, 8'h00, 1'b0, "t1_ovf");
        peek(2'd1, 8'hA0, 1'b1, "t1_reload");
        peek(2'd1, 8'hA0, 1'b0, "t1_after");

        // 2: TIMA write during the overflow cycle cancels the reload
        wr(2'd1, 8'hFF);
        fall262();
        wr(2'd1, 8'h33);
        peek(2'd1, 8'h33, 1'b0, "t2_tima");
        peek(2'd2, 8'hA0, 1'b0, "t2_tma");

        // 3: in the reload cycle a TIMA write is ignored, a TMA write lands in both
        wr(2'd1, 8'hFF);
        fall262();
        peek(2'd1, 8'h00, 1'b0, "t3_ovf");
        wr(2'd1, 8'h55);
        peek(2'd1, 8'hA0, 1'b0, "t3_ignored");
        wr(2'd1, 8'hFF);
        fall262();
        rd(2'd1);
        wr(2'd2, 8'h77);
        peek(2'd1, 8'h77, 1'b0, "t3_tima77");
        peek(2'd2, 8'h77, 1'b0, "t3_tma77");

        // 4: disabling the timer while the tap is high gives exactly one inc
        wr(2'd1, 8'h10);
        t4096 = 1'b1;
        wr(2'd3, 8'h04);
        rd(2'd1);
        wr(2'd3, 8'h00);
        peek(2'd1, 8'h10, 1'b0, "t4_before");
        peek(2'd1, 8'h11, 1'b0, "t4_glitch");
        for (int i = 0; i < 8; i++) begin
            t4096 = i[0]; t262144 = i[1]; t65536 = ~i[0]; t16384 = i[2];
            rd(2'd1);
        end
        t4096 = 1'b0; t262144 = 1'b0; t65536 = 1'b0; t16384 = 1'b0;
        rd(2'd1);
        peek(2'd1, 8'h11, 1'b0, "t4_stable");

        // 5: read-back and bus release
        wr(2'd3, 8'h06);
        peek(2'd3, 8'hFE, 1'b0, "t5_tac");
        peek(2'd1, 8'h11, 1'b0, "t5_tima");
        peek(2'd2, 8'h77, 1'b0, "t5_tma");
        peek_float(1'b1, 1'b1, 2'd0, "t5_div_float");
        peek_float(1'b0, 1'b1, 2'd1, "t5_nord_float");
        peek_float(1'b1, 1'b0, 2'd1, "t5_nosel_float");

        // 6: reset during the overflow cycle
        wr(2'd3, 8'h05);
        wr(2'd1, 8'hFF);
        fall262();
        cpu_rd = 1'b1; ff_sel = 1'b1; addr = 2'd1;
        #1;
        check("t6_ovf", d, 8'h00);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_int", {7'b0, int_timer}, 8'h00);
        check("t6_rst_tima", d, 8'h00);
        @(posedge clk);
        #1;
        rd(2'd1);
        reset = 1'b0;
        rd(2'd1);
        peek(2'd1, 8'h00, 1'b0, "t6_tima");
        peek(2'd2, 8'h00, 1'b0, "t6_tma");
        peek(2'd3, 8'hF8, 1'b0, "t6_tac");
        repeat (4) rd(2'd1);
        peek(2'd1, 8'h00, 1'b0, "t6_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
